// File: rtl/rate_counter_if.sv
// Key, control and status signals of rate_counter.
// The bench drives through the master modport; the counter uses slave.
interface rate_counter_if #(
  parameter int unsigned w_cnt = 32
);
  logic             faster;
  logic             slower;
  logic             down;
  logic             pause;
  logic             load;
  logic [w_cnt-1:0] load_value;
  logic [w_cnt-1:0] count;
  logic             tick;
  logic [31:0]      period;
  logic             at_min;
  logic             at_max;

  modport master (
    output faster, slower, down, pause, load, load_value,
    input  count, tick, period, at_min, at_max
  );

  modport slave (
    input  faster, slower, down, pause, load, load_value,
    output count, tick, period, at_min, at_max
  );
endinterface

// File: rtl/rate_counter.sv
// Up/down counter stepped by a prescaler whose period is halved/doubled by key releases.
// Define RATE_COUNTER_WRAP_EN for a wrapping count; the default build saturates.
module rate_counter #(
  parameter int unsigned clk_mhz     = 50,
  parameter int unsigned w_cnt       = 32,
  parameter int unsigned min_period  = clk_mhz * 1000 * 1000 / 50,
  parameter int unsigned max_period  = clk_mhz * 1000 * 1000 * 3,
  parameter int unsigned init_period = clk_mhz * 1000 * 1000
) (
  input  logic           clk,
  input  logic           rst,
  rate_counter_if.slave  bus
);

  localparam logic [31:0] MIN_P  = 32'(min_period);
  localparam logic [31:0] MAX_P  = 32'(max_period);
  localparam logic [31:0] INIT_P = 32'(init_period);

  logic             faster_q;
  logic             slower_q;
  logic [31:0]      period_q;
  logic [31:0]      presc_q;
  logic [w_cnt-1:0] count_q;

  logic             rel_f;
  logic             rel_s;
  logic [32:0]      doubled;
  logic [31:0]      halved;
  logic [31:0]      period_next;
  logic             tick;
  logic [w_cnt-1:0] count_step;

  always_comb begin
    rel_f       = faster_q & ~bus.faster;
    rel_s       = slower_q & ~bus.slower;
    doubled     = {period_q, 1'b0};
    halved      = period_q >> 1;
    period_next = period_q;
    if (rel_s && !rel_f) begin
      period_next = (doubled > {1'b0, MAX_P}) ? MAX_P : doubled[31:0];
    end else if (rel_f && !rel_s) begin
      period_next = (halved < MIN_P) ? MIN_P : halved;
    end
  end

  // Gated by rst so that a held reset never shows a strobe from the cleared prescaler.
  always_comb begin
    tick = ~rst & ~bus.pause & ~bus.load & (presc_q == '0);
  end

  always_comb begin
    count_step = count_q;
`ifdef RATE_COUNTER_WRAP_EN
    if (bus.down) count_step = count_q - w_cnt'(1);
    else          count_step = count_q + w_cnt'(1);
`else
    if (bus.down) begin
      if (count_q != '0) count_step = count_q - w_cnt'(1);
    end else begin
      if (count_q != '1) count_step = count_q + w_cnt'(1);
    end
`endif
  end

  // Reloads use period_next so a release landing on a reload cycle applies immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      faster_q <= 1'b0;
      slower_q <= 1'b0;
      period_q <= INIT_P;
      presc_q  <= '0;
      count_q  <= '0;
    end else begin
      faster_q <= bus.faster;
      slower_q <= bus.slower;
      period_q <= period_next;
      if (bus.load) begin
        count_q <= bus.load_value;
        presc_q <= period_next - 32'd1;
      end else if (!bus.pause) begin
        if (presc_q == '0) begin
          presc_q <= period_next - 32'd1;
          count_q <= count_step;
        end else begin
          presc_q <= presc_q - 32'd1;
        end
      end
    end
  end

  assign bus.count  = count_q;
  assign bus.tick   = tick;
  assign bus.period = period_q;
  assign bus.at_min = (period_q == MIN_P);
  assign bus.at_max = (period_q == MAX_P);

endmodule

// File: tb/tb_rate_counter.sv
// Bench for rate_counter: directed scenarios then random key/pause/load traffic,
// checked every cycle against a deadline-based reference model.
module tb_rate_counter;
  localparam int unsigned W     = 4;
  localparam int unsigned MINP  = 4;
  localparam int unsigned MAXP  = 64;
  localparam int unsigned INITP = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rate_counter_if #(.w_cnt(W)) bus ();

  rate_counter #(
    .clk_mhz    (1),
    .w_cnt      (W),
    .min_period (MINP),
    .max_period (MAXP),
    .init_period(INITP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: the model tracks the absolute cycle of the next tick.
  int unsigned cyc        = 0;
  int unsigned m_deadline = 0;
  int unsigned m_period   = 0;
  int unsigned m_count    = 0;
  bit          m_pf       = 0;
  bit          m_ps       = 0;
  bit          m_valid    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned step_count(input int unsigned c, input bit d);
    int unsigned top = (1 << W) - 1;
`ifdef RATE_COUNTER_WRAP_EN
    if (d) return (c == 0) ? top : c - 1;
    else   return (c == top) ? 0 : c + 1;
`else
    if (d) return (c == 0) ? 0 : c - 1;
    else   return (c == top) ? top : c + 1;
`endif
  endfunction

  task automatic cycle(input bit r, input bit f, input bit s, input bit d,
                       input bit p, input bit l, input logic [W-1:0] lv);
    bit          rel_f, rel_s, exp_tick;
    int unsigned newp;
    @(negedge clk);
    rst = r; bus.faster = f; bus.slower = s; bus.down = d;
    bus.pause = p; bus.load = l; bus.load_value = lv;
    #1;
    rel_f = m_pf && !f;
    rel_s = m_ps && !s;
    newp  = m_period;
    if (rel_s && !rel_f)      newp = (2 * m_period > MAXP) ? MAXP : 2 * m_period;
    else if (rel_f && !rel_s) newp = (m_period / 2 < MINP) ? MINP : m_period / 2;
    exp_tick = !r && !p && !l && (cyc == m_deadline);
    if (m_valid) begin
      chk("tick",   bus.tick,   exp_tick);
      chk("count",  bus.count,  m_count);
      chk("period", bus.period, m_period);
      chk("at_min", bus.at_min, m_period == MINP);
      chk("at_max", bus.at_max, m_period == MAXP);
    end
    if (r) begin
      m_count = 0; m_period = INITP; m_deadline = cyc + 1;
      m_pf = 0; m_ps = 0; m_valid = 1;
    end else if (m_valid) begin
      m_period = newp; m_pf = f; m_ps = s;
      if (l) begin
        m_count = lv; m_deadline = cyc + newp;
      end else if (p) begin
        m_deadline = m_deadline + 1;
      end else if (exp_tick) begin
        m_count = step_count(m_count, d); m_deadline = cyc + newp;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic key(input bit f, input bit s);
    cycle(0, f, s, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic wait_tick(input string tag);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cycle(0, 0, 0, 0, 0, 0, '0);
      seen = bus.tick;
    end
    chk(tag, seen, 1'b1);
  endtask

  initial begin
    int unsigned snap;
    bit          saw;
    bit          f, s, d, p, l, r;
    logic [W-1:0] lv;

    rst = 1'b1;
    bus.faster = 0; bus.slower = 0; bus.down = 0;
    bus.pause = 0; bus.load = 0; bus.load_value = '0;

    // Reset, then first tick on the first free cycle and every 16 after.
    cycle(1, 0, 0, 0, 0, 0, '0);
    cycle(1, 0, 0, 0, 0, 0, '0);
    cycle(1, 0, 0, 0, 0, 0, '0);
    chk("rst_tick",   bus.tick,   1'b0);
    chk("rst_count",  bus.count,  0);
    chk("rst_period", bus.period, INITP);
    cycle(0, 0, 0, 0, 0, 0, '0);
    chk("first_tick", bus.tick, 1'b1);
    idle(40);
    chk("three_ticks", bus.count, 3);

    // Slower thrice to the ceiling, then faster once.
    key(0, 1); chk("slow_32", bus.period, 32);
    key(0, 1); chk("slow_64", bus.period, 64);
    key(0, 1); chk("slow_sat", bus.period, 64); chk("at_max", bus.at_max, 1'b1);
    key(1, 0); chk("fast_32", bus.period, 32);

    // Down to the floor, then simultaneous release is ignored.
    key(1, 0); key(1, 0); chk("fast_8", bus.period, 8);
    key(1, 0); chk("fast_4", bus.period, 4);
    key(1, 0); chk("fast_sat", bus.period, 4); chk("at_min", bus.at_min, 1'b1);
    key(1, 1); chk("both_keys", bus.period, 4);

    // Load all-ones then step up once.
    cycle(0, 0, 0, 0, 0, 1, 4'hF);
    wait_tick("load_wait_tick");
    cycle(0, 0, 0, 0, 0, 0, '0);
`ifdef RATE_COUNTER_WRAP_EN
    chk("wrap_up", bus.count, 0);
`else
    chk("sat_up", bus.count, 15);
`endif

    // Pause mid-interval: no tick, count frozen.
    key(0, 1); key(0, 1);
    wait_tick("pause_wait_tick");
    idle(5);
    snap = bus.count;
    saw = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(0, 0, 0, 0, 1, 0, '0);
      saw |= bus.tick;
    end
    chk("pause_no_tick", saw, 1'b0);
    chk("pause_count",   bus.count, snap);
    idle(20);

    // Load plus slower release on the reload cycle.
    key(1, 0); key(1, 0);
    saw = 0;
    for (int i = 0; i < 200 && !saw; i++) begin
      if (m_deadline == cyc + 1) saw = 1;
      else cycle(0, 0, 0, 0, 0, 0, '0);
    end
    chk("reload_align", saw, 1'b1);
    cycle(0, 0, 1, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, 0, 1, 4'd9);
    chk("load_no_tick", bus.tick, 1'b0);
    cycle(0, 0, 0, 0, 0, 0, '0);
    chk("load_value", bus.count, 9);
    idle(20);

    // Random traffic.
    f = 0; s = 0; d = 0; p = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5) == 0)  f = ~f;
      if ($urandom_range(5) == 0)  s = ~s;
      if ($urandom_range(29) == 0) d = ~d;
      if ($urandom_range(11) == 0) p = ~p;
      l  = !p && ($urandom_range(39) == 0);
      r  = ($urandom_range(299) == 0);
      lv = W'($urandom);
      cycle(r, f, s, d, p, l, lv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rate_counter.md
RATE_COUNTER -- requirements
Module: rate_counter

Interface
REQ-001 SHALL have parameter clk_mhz, default 50: clock frequency in MHz.
REQ-002 SHALL have parameter w_cnt, default 32: width of the displayed count.
REQ-003 SHALL have parameter min_period, default clk_mhz*1000*1000/50: minimum tick period in clocks, at least 2.
REQ-004 SHALL have parameter max_period, default clk_mhz*1000*1000*3: maximum tick period in clocks, at least 2*min_period and below 2^32.
REQ-005 SHALL have parameter init_period, default clk_mhz*1000*1000: period after reset, within [min_period, max_period].
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-008 SHALL have port faster, input, 1 bit: key level, high while pressed.
REQ-009 SHALL have port slower, input, 1 bit: key level, high while pressed.
REQ-010 SHALL have port down, input, 1 bit: count direction, 1 counts down, 0 counts up.
REQ-011 SHALL have port pause, input, 1 bit: freezes the prescaler and count while high.
REQ-012 SHALL have port load, input, 1 bit: loads load_value into count.
REQ-013 SHALL have port load_value, input, w_cnt bits: value loaded into count.
REQ-014 SHALL have port count, output, w_cnt bits: current count.
REQ-015 SHALL have port tick, output, 1 bit: one-cycle strobe on each count step.
REQ-016 SHALL have port period, output, 32 bits: current period in clocks.
REQ-017 SHALL have ports at_min and at_max, outputs, 1 bit each: high when period equals min_period or max_period.

Function
REQ-018 SHALL register faster and slower once and act on the release edge (registered 1, current 0) only.
REQ-019 On a slower release, period SHALL become min(period*2, max_period), with the product computed in 33 bits.
REQ-020 On a faster release, period SHALL become max(period/2, min_period), using truncating division.
REQ-021 If both keys release in the same cycle, period SHALL remain unchanged.
REQ-022 The prescaler SHALL load period-1 when it is 0 and decrement otherwise; it SHALL freeze while pause is high.
REQ-023 tick SHALL be 1 exactly in cycles where prescaler==0, pause==0 and load==0; the spacing between ticks is period clocks.
REQ-024 A period change SHALL take effect at the next prescaler reload; the current interval completes at the old period.
REQ-025 On tick, count SHALL change by +1 (down==0) or -1 (down==1), registered, and visible the cycle after tick.
REQ-026 load SHALL override tick: count takes load_value next cycle, the prescaler reloads period-1, and no step occurs.
REQ-027 Key releases SHALL be processed while pause is high.
REQ-028 at_min and at_max SHALL be derived combinationally from the period register.

Reset
REQ-029 While rst is high at a clock edge, the following SHALL hold next cycle: count=0, period=init_period, prescaler=0, tick=0, key registers=0.
REQ-030 Reset mid-interval SHALL discard the pending period and interval; the first tick after reset occurs in the first cycle after rst deasserts.

Configuration
REQ-031 With `RATE_COUNTER_WRAP_EN` defined, count SHALL wrap modulo 2^w_cnt in both directions (all-ones+1 gives 0; 0-1 gives all-ones).
REQ-032 Without `RATE_COUNTER_WRAP_EN`, count SHALL saturate at all-ones counting up and at 0 counting down; tick still pulses.

Verification
REQ-033 Scenario: min_period=4, max_period=64, init_period=16; release reset -> tick at cycle 1, then every 16 clocks; count 0,1,2,...
REQ-034 Scenario: from period=16, release slower three times -> period goes 32, 64, 64 with at_max=1; release faster -> 32.
REQ-035 Scenario: from period=8, release faster twice -> period goes 4 then stays 4, at_min=1; release both keys in the same cycle -> period stays 4.
REQ-036 Scenario: w_cnt=4, load_value=15 with load, then down=0 and one tick -> count=0 with WRAP_EN, count=15 without.
REQ-037 Scenario: hold pause for 50 clocks mid-interval -> no tick and count constant; after pause drops, the tick arrives after the remaining interval.
REQ-038 Scenario: assert load and slower release in the same cycle that prescaler==0 -> count=load_value, no tick, new period used from that reload.
